fare_select_frame: RTL and testbench
====================================

Name: fare_select_frame

Overview:
Parametrised ticket-selection front end for the vending machine. It samples NUM_ST one-hot station buttons and debounces them. It then looks up the fare and station ID in a runtime-programmable table. The result goes to the downstream payment/compare logic as a 3-beat frame (header, fare, station ID) over a valid/ready stream. Invalid presses (multi-hot, unprogrammed fare) are flagged and never produce a frame.

Parameters:
NUM_ST, 8, number of station buttons (2..16)
DW, 8, width of fare, station ID and output data
DEB_CYC, 4, consecutive identical samples required to accept a button pattern (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
but  in  NUM_ST  raw station buttons, bit i = station i
cfg_we  in  1  table write strobe
cfg_addr  in  $clog2(NUM_ST)  table entry index
cfg_fee  in  DW  fare to store
cfg_id  in  DW  station ID to store
out_valid  out  1  frame beat valid
out_ready  in  1  downstream accepts beat
out_data  out  DW  beat payload
out_last  out  1  final beat of frame
done  out  1  one-cycle pulse after last beat accepted
err  out  1  one-cycle pulse on rejected press
busy  out  1  high from press acceptance until buttons released

Behaviour:
- Reset (async): out_valid, out_data, out_last, done, err, busy = 0; FSM = IDLE; debounce counter = 0.
- Reset loads table entries 0..7 from package defaults. Fares: 16,23,26,30,33,37,40,44. IDs: 1,2,3,4,5,6,7,23. Entries >= 8 reset to fee 0, id 0.
- Table write: on an edge with cfg_we=1 and cfg_addr<NUM_ST, the entry is updated. Writes with cfg_addr>=NUM_ST are ignored. Writes are legal in any state.
- Debounce: but is registered once (but_q). A counter increments while but_q equals its previous value, saturating at DEB_CYC, and clears to 1 on any change. The pattern is "stable" when the count equals DEB_CYC.
- FSM states: IDLE, HDR, FEE, SID, DONE, WREL.
- IDLE → HDR: stable pattern is exactly one-hot (bit i) and fee[i] != 0.
  - On that edge, fee[i], id[i] and index i are snapshotted.
  - busy is set.
  - out_valid = 1 from the next cycle.
- IDLE → WREL with err pulse (1 cycle, coincident with the transition edge):
  - stable pattern is multi-hot; or
  - stable pattern is one-hot but fee[i] == 0.
  - busy is set.
- Stable all-zero in IDLE: no action.
- HDR: out_data = i+1, zero-extended to DW.
- FEE: out_data = snapshot fee.
- SID: out_data = snapshot id, out_last = 1.
- Each beat advances only on an edge with out_valid && out_ready. out_data/out_last hold stable while stalled. Beat order is HDR → FEE → SID.
- SID accepted → DONE:
  - out_valid, out_last and out_data drop to 0.
  - done = 1 for exactly one cycle.
  - next state is WREL.
- WREL → IDLE: when the stable pattern is all-zero; busy clears on that edge.
- Button activity from HDR through WREL never starts a new frame. A held button therefore yields exactly one frame.
- Table writes after the snapshot do not affect the in-flight frame.
- Latency, from the first edge sampling a new pattern into but_q, with out_ready tied to 1:
  - out_valid rises after DEB_CYC edges;
  - frame occupies 3 cycles;
  - done follows the SID-accept edge.
- Reset mid-frame aborts immediately with no done pulse. The table returns to defaults.

Decomposition:
- Package fare_pkg:
  - state enum (IDLE, HDR, FEE, SID, DONE, WREL);
  - default fee and ID constant arrays (8 entries);
  - function is_onehot and function onehot_to_idx.
- Sub-module button_debounce, parametrised by WIDTH and DEB_CYC.
  - Outputs stable_pat and a stable flag.
  - Reused for the coin-input path.
- Table and FSM stay in fare_select_frame.

Test Plan:
1. Defaults, DEB_CYC=4, out_ready=1. Press bit 2 held 20 cycles → single frame 3,26,3 with out_last on beat 3, done pulse once, busy low after release is stable 4 cycles.
2. Press bit 7 with out_ready low for 5 cycles on each beat → beats 8,44,23 held stable through stalls, no beat lost or duplicated.
3. Bouncing input: bit 0 toggling every 2 cycles for 10 cycles, then held → exactly one frame 1,16,1, emitted only after 4 stable samples.
4. Press 8'b0001_0100 held → err pulse once, no out_valid, busy until release. Then write cfg_addr=5 fee 0 and press bit 5 → err, no frame.
5. Write entry 1 fee 50 id 9, then press bit 1 → frame 2,50,9. During the HDR stall, write entry 1 fee 60 → frame still carries 50.
6. Assert rst during the FEE beat → outputs 0 immediately, no done. After release, press bit 1 → frame 2,23,2 (defaults restored).

Source files
------------

// File: rtl/fare_select_frame_pkg.sv
// Shared state encoding, factory fare table and one-hot helpers for the
// ticket-selection front end.
package fare_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      FEE,
      SID,
      DONE,
      WREL
   } state_t;

   localparam int MAX_ST      = 16;
   localparam int DEF_ENTRIES = 8;

   // Factory table loaded on every reset; entries past the end come up unprogrammed.
   localparam int DEF_FEE [DEF_ENTRIES] = '{16, 23, 26, 30, 33, 37, 40, 44};
   localparam int DEF_ID  [DEF_ENTRIES] = '{1, 2, 3, 4, 5, 6, 7, 23};

   function automatic logic is_onehot(input logic [MAX_ST-1:0] v);
      return (v != '0) && ((v & (v - MAX_ST'(1))) == '0);
   endfunction

   function automatic logic [3:0] onehot_to_idx(input logic [MAX_ST-1:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_ST; i++) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/fare_select_frame_if.sv
// Beat stream from the ticket selector to the payment/compare logic.
interface fare_select_frame_if #(
   parameter int DW = 8
);
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/fare_select_frame_debounce.sv
// Generic button debouncer: registers the raw inputs and flags a pattern as
// stable once it has been sampled DEB_CYC times in a row.
module button_debounce #(
   parameter int WIDTH   = 8,
   parameter int DEB_CYC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] stable_pat,
   output logic             stable
);

   localparam int            CW      = $clog2(DEB_CYC + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC);

   logic [WIDTH-1:0] raw_q;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;

   // Counting the incoming sample against the held one keeps cnt_q equal to
   // the number of identical samples currently sitting in raw_q.
   always_comb begin
      cnt_d = cnt_q;
      if (raw != raw_q) begin
         cnt_d = CW'(1);
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         raw_q <= '0;
         cnt_q <= '0;
      end else begin
         raw_q <= raw;
         cnt_q <= cnt_d;
      end
   end

   assign stable_pat = raw_q;
   assign stable     = (cnt_q == CNT_MAX);

endmodule

// File: rtl/fare_select_frame.sv
// Ticket-selection front end: debounced station press -> fare table lookup ->
// three-beat frame (header, fare, station ID) on a valid/ready stream.
module fare_select_frame
   import fare_pkg::*;
#(
   parameter int NUM_ST  = 8,
   parameter int DW      = 8,
   parameter int DEB_CYC = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_ST-1:0]         but,
   input  logic                      cfg_we,
   input  logic [$clog2(NUM_ST)-1:0] cfg_addr,
   input  logic [DW-1:0]             cfg_fee,
   input  logic [DW-1:0]             cfg_id,
   fare_select_frame_if.master       out_if,
   output logic                      done,
   output logic                      err,
   output logic                      busy
);

   localparam int AW = $clog2(NUM_ST);

   logic [NUM_ST-1:0] stablePat;
   logic              stable;
   logic              patOneHot;
   logic              patZero;
   logic [AW-1:0]     patIdx;
   logic [DW-1:0]     patFee;

   logic [DW-1:0]     feeTab_q [NUM_ST];
   logic [DW-1:0]     idTab_q  [NUM_ST];

   state_t            state_q;
   logic [DW-1:0]     feeSnap_q;
   logic [DW-1:0]     idSnap_q;
   logic [DW-1:0]     data_q;
   logic              valid_q;
   logic              last_q;
   logic              done_q;
   logic              err_q;
   logic              busy_q;

   button_debounce #(
      .WIDTH   (NUM_ST),
      .DEB_CYC (DEB_CYC)
   ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .raw        (but),
      .stable_pat (stablePat),
      .stable     (stable)
   );

   assign patOneHot = is_onehot(MAX_ST'(stablePat));
   assign patZero   = (stablePat == '0);
   assign patIdx    = AW'(onehot_to_idx(MAX_ST'(stablePat)));
   assign patFee    = feeTab_q[patIdx];

   // Fare table; the FSM snapshots from it, so later writes never reach a frame in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ST; i++) begin
            feeTab_q[i] <= (i < DEF_ENTRIES) ? DW'(DEF_FEE[i % DEF_ENTRIES]) : '0;
            idTab_q[i]  <= (i < DEF_ENTRIES) ? DW'(DEF_ID[i % DEF_ENTRIES])  : '0;
         end
      end else if (cfg_we && (32'(cfg_addr) < NUM_ST)) begin
         feeTab_q[cfg_addr] <= cfg_fee;
         idTab_q[cfg_addr]  <= cfg_id;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         feeSnap_q <= '0;
         idSnap_q  <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (stable && !patZero) begin
                  busy_q <= 1'b1;
                  if (patOneHot && (patFee != '0)) begin
                     feeSnap_q <= patFee;
                     idSnap_q  <= idTab_q[patIdx];
                     data_q    <= DW'(patIdx) + DW'(1);
                     valid_q   <= 1'b1;
                     last_q    <= 1'b0;
                     state_q   <= HDR;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= WREL;
                  end
               end
            end
            HDR: begin
               if (out_if.out_ready) begin
                  data_q  <= feeSnap_q;
                  state_q <= FEE;
               end
            end
            FEE: begin
               if (out_if.out_ready) begin
                  data_q  <= idSnap_q;
                  last_q  <= 1'b1;
                  state_q <= SID;
               end
            end
            SID: begin
               if (out_if.out_ready) begin
                  data_q  <= '0;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= WREL;
            end
            // Holding here until the buttons are released is what limits a held press to one frame.
            WREL: begin
               if (stable && patZero) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_if.out_valid = valid_q;
   assign out_if.out_data  = data_q;
   assign out_if.out_last  = last_q;
   assign done             = done_q;
   assign err              = err_q;
   assign busy             = busy_q;

endmodule

// File: tb/tb_fare_select_frame.sv
// Self-checking bench for fare_select_frame: table vectors, hand-written corner
// sequences and randomized presses against a station-level reference table.
`timescale 1ns/1ps
module tb_fare_select_frame;

   localparam int NUM_ST  = 8;
   localparam int DW      = 8;
   localparam int DEB_CYC = 4;
   localparam int AW      = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [NUM_ST-1:0] but;
   logic              cfg_we;
   logic [AW-1:0]     cfg_addr;
   logic [DW-1:0]     cfg_fee;
   logic [DW-1:0]     cfg_id;
   logic              done;
   logic              err;
   logic              busy;

   fare_select_frame_if #(.DW(DW)) outIf ();

   fare_select_frame #(
      .NUM_ST  (NUM_ST),
      .DW      (DW),
      .DEB_CYC (DEB_CYC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .but      (but),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_fee  (cfg_fee),
      .cfg_id   (cfg_id),
      .out_if   (outIf),
      .done     (done),
      .err      (err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      logic [7:0] pat;
      bit         expErr;
      int         hdr;
      int         fee;
      int         id;
   } vec_t;

   // Station-level view of the fare table: station i costs modelFee[i].
   int tbDefFee [8] = '{16, 23, 26, 30, 33, 37, 40, 44};
   int tbDefId  [8] = '{1, 2, 3, 4, 5, 6, 7, 23};
   int modelFee [NUM_ST];
   int modelId  [NUM_ST];

   beat_t beatQ[$];
   int    doneCnt;
   int    errCnt;
   int    nChecks;
   int    nFail;

   logic          stallPrev;
   logic [DW-1:0] stallData;
   logic          stallLast;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Mid-cycle monitor: logs accepted beats and pulses, and checks stalled beats hold.
   always @(negedge clk) begin
      if (rst) begin
         stallPrev = 1'b0;
      end else begin
         if (stallPrev) begin
            checkOutput("stallValid", 32'(outIf.out_valid), 32'd1);
            checkOutput("stallData", 32'(outIf.out_data), 32'(stallData));
            checkOutput("stallLast", 32'(outIf.out_last), 32'(stallLast));
         end
         if (outIf.out_valid && outIf.out_ready) begin
            beat_t b;
            b.data = outIf.out_data;
            b.last = outIf.out_last;
            beatQ.push_back(b);
         end
         stallPrev = outIf.out_valid && !outIf.out_ready;
         stallData = outIf.out_data;
         stallLast = outIf.out_last;
         if (done) doneCnt++;
         if (err) errCnt++;
      end
   end

   task automatic modelReset();
      for (int i = 0; i < NUM_ST; i++) begin
         modelFee[i] = (i < 8) ? tbDefFee[i] : 0;
         modelId[i]  = (i < 8) ? tbDefId[i] : 0;
      end
   endtask

   function automatic void modelPress(input logic [7:0] pat, output bit expErr,
                                      output int hdr, output int fee, output int id);
      int ones;
      int idx;
      ones = 0;
      idx  = 0;
      for (int i = 0; i < NUM_ST; i++) begin
         if (pat[i]) begin
            ones++;
            idx = i;
         end
      end
      expErr = (ones != 1) || (modelFee[idx] == 0);
      hdr    = idx + 1;
      fee    = modelFee[idx];
      id     = modelId[idx];
   endfunction

   task automatic clearObs();
      beatQ.delete();
      doneCnt = 0;
      errCnt  = 0;
   endtask

   task automatic resetDut();
      rst             = 1'b1;
      but             = '0;
      cfg_we          = 1'b0;
      cfg_addr        = '0;
      cfg_fee         = '0;
      cfg_id          = '0;
      outIf.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();
   endtask

   task automatic cfgWrite(input int addr, input int fee, input int id);
      cfg_we   = 1'b1;
      cfg_addr = AW'(addr);
      cfg_fee  = DW'(fee);
      cfg_id   = DW'(id);
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      modelFee[addr] = fee;
      modelId[addr]  = id;
   endtask

   task automatic waitValid(input string tag);
      int c;
      c = 0;
      while (!outIf.out_valid && c < 60) begin
         @(posedge clk);
         #1;
         c++;
      end
      if (!outIf.out_valid) checkOutput({tag, "_validTimeout"}, 32'd0, 32'd1);
   endtask

   task automatic waitDone(input string tag);
      int c;
      c = 0;
      while (doneCnt == 0 && c < 60) begin
         @(posedge clk);
         #1;
         c++;
      end
      if (doneCnt == 0) checkOutput({tag, "_doneTimeout"}, 32'd0, 32'd1);
   endtask

   task automatic releaseAndWait(input string tag);
      int r;
      but             = '0;
      outIf.out_ready = 1'b1;
      r = 0;
      while (busy && r < 100) begin
         @(posedge clk);
         #1;
         r++;
      end
      checkOutput({tag, "_releaseLat"}, 32'(r), 32'(DEB_CYC + 1));
   endtask

   // Holds pat until the press resolves (and at least holdCyc cycles), then releases.
   task automatic applyStimulus(input string tag, input logic [7:0] pat, input int holdCyc,
                                input bit randReady, input bit randWrite, output int lat);
      bit finished;
      int c;
      clearObs();
      lat      = -1;
      finished = 1'b0;
      c        = 0;
      if (!randReady) outIf.out_ready = 1'b1;
      but = pat;
      while (c < 300 && !(finished && c >= holdCyc)) begin
         @(posedge clk);
         #1;
         c++;
         cfg_we = 1'b0;
         if (lat < 0 && outIf.out_valid) lat = c;
         if (doneCnt > 0 || errCnt > 0) finished = 1'b1;
         if (randReady) outIf.out_ready = ($urandom_range(0, 3) != 0);
         if (randWrite && lat >= 0 && $urandom_range(0, 4) == 0) begin
            cfg_we   = 1'b1;
            cfg_addr = AW'($urandom_range(0, NUM_ST - 1));
            cfg_fee  = DW'($urandom_range(0, 255));
            cfg_id   = DW'($urandom_range(0, 255));
            modelFee[cfg_addr] = int'(cfg_fee);
            modelId[cfg_addr]  = int'(cfg_id);
         end
      end
      if (cfg_we) begin
         @(posedge clk);
         #1;
         cfg_we = 1'b0;
      end
      if (!finished) checkOutput({tag, "_pressTimeout"}, 32'd0, 32'd1);
      checkOutput({tag, "_busyHeld"}, 32'(busy), 32'd1);
      releaseAndWait(tag);
   endtask

   task automatic checkFrame(input string tag, input bit expErr, input int hdr,
                             input int fee, input int id);
      if (expErr) begin
         checkOutput({tag, "_err"}, 32'(errCnt), 32'd1);
         checkOutput({tag, "_beats"}, 32'(beatQ.size()), 32'd0);
         checkOutput({tag, "_done"}, 32'(doneCnt), 32'd0);
      end else begin
         checkOutput({tag, "_err"}, 32'(errCnt), 32'd0);
         checkOutput({tag, "_beats"}, 32'(beatQ.size()), 32'd3);
         checkOutput({tag, "_done"}, 32'(doneCnt), 32'd1);
         if (beatQ.size() == 3) begin
            checkOutput({tag, "_hdr"}, 32'(beatQ[0].data), 32'(hdr));
            checkOutput({tag, "_fee"}, 32'(beatQ[1].data), 32'(fee));
            checkOutput({tag, "_id"}, 32'(beatQ[2].data), 32'(id));
            checkOutput({tag, "_last0"}, 32'(beatQ[0].last), 32'd0);
            checkOutput({tag, "_last1"}, 32'(beatQ[1].last), 32'd0);
            checkOutput({tag, "_last2"}, 32'(beatQ[2].last), 32'd1);
         end
      end
   endtask

   initial begin
      vec_t       vecs [6];
      int         lat;
      bit         expErr;
      int         eHdr;
      int         eFee;
      int         eId;
      logic [7:0] pat;

      nChecks = 0;
      nFail   = 0;
      clearObs();

      vecs[0] = '{8'h01, 1'b0, 1, 16, 1};
      vecs[1] = '{8'h08, 1'b0, 4, 30, 4};
      vecs[2] = '{8'h40, 1'b0, 7, 40, 7};
      vecs[3] = '{8'h80, 1'b0, 8, 44, 23};
      vecs[4] = '{8'h03, 1'b1, 0, 0, 0};
      vecs[5] = '{8'hFF, 1'b1, 0, 0, 0};

      // Reset values, sampled while reset is still asserted.
      rst = 1'b1;
      #2;
      checkOutput("rst_valid", 32'(outIf.out_valid), 32'd0);
      checkOutput("rst_data", 32'(outIf.out_data), 32'd0);
      checkOutput("rst_last", 32'(outIf.out_last), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      resetDut();
      repeat (DEB_CYC + 2) @(posedge clk);
      #1;
      checkOutput("idleZero_busy", 32'(busy), 32'd0);

      for (int v = 0; v < 6; v++) begin
         applyStimulus($sformatf("vec%0d", v), vecs[v].pat, 8, 1'b0, 1'b0, lat);
         checkFrame($sformatf("vec%0d", v), vecs[v].expErr, vecs[v].hdr, vecs[v].fee, vecs[v].id);
      end

      // Held press: one frame only, fixed latency.
      applyStimulus("t1", 8'h04, 20, 1'b0, 1'b0, lat);
      checkOutput("t1_latency", 32'(lat), 32'(DEB_CYC + 1));
      checkFrame("t1", 1'b0, 3, 26, 3);

      // Five-cycle stall on every beat.
      clearObs();
      outIf.out_ready = 1'b0;
      but = 8'h80;
      waitValid("t2");
      for (int b = 0; b < 3; b++) begin
         repeat (5) @(posedge clk);
         #1;
         outIf.out_ready = 1'b1;
         @(posedge clk);
         #1;
         outIf.out_ready = 1'b0;
      end
      waitDone("t2");
      releaseAndWait("t2");
      checkFrame("t2", 1'b0, 8, 44, 23);

      // Bouncing bit 0 must stay quiet until it settles.
      clearObs();
      for (int k = 0; k < 10; k++) begin
         but = ((k / 2) % 2 == 1) ? 8'h01 : 8'h00;
         @(posedge clk);
         #1;
      end
      checkOutput("t3_bounceBeats", 32'(beatQ.size()), 32'd0);
      checkOutput("t3_bounceErr", 32'(errCnt), 32'd0);
      applyStimulus("t3", 8'h01, 10, 1'b0, 1'b0, lat);
      checkOutput("t3_latency", 32'(lat), 32'(DEB_CYC + 1));
      checkFrame("t3", 1'b0, 1, 16, 1);

      // Rejected presses: multi-hot, then a station whose fare was zeroed.
      applyStimulus("t4a", 8'h14, 10, 1'b0, 1'b0, lat);
      checkFrame("t4a", 1'b1, 0, 0, 0);
      cfgWrite(5, 0, 6);
      applyStimulus("t4b", 8'h20, 10, 1'b0, 1'b0, lat);
      checkFrame("t4b", 1'b1, 0, 0, 0);

      // Reprogrammed entry, then a rewrite during the header stall.
      cfgWrite(1, 50, 9);
      clearObs();
      outIf.out_ready = 1'b0;
      but = 8'h02;
      waitValid("t5");
      checkOutput("t5_hdrHold", 32'(outIf.out_data), 32'd2);
      cfgWrite(1, 60, 9);
      outIf.out_ready = 1'b1;
      waitDone("t5");
      releaseAndWait("t5");
      checkFrame("t5", 1'b0, 2, 50, 9);

      // Reset during the fare beat aborts the frame and restores the table.
      clearObs();
      outIf.out_ready = 1'b0;
      but = 8'h02;
      waitValid("t6");
      outIf.out_ready = 1'b1;
      @(posedge clk);
      #1;
      outIf.out_ready = 1'b0;
      checkOutput("t6_feeBeat", 32'(outIf.out_data), 32'd60);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t6_rstValid", 32'(outIf.out_valid), 32'd0);
      checkOutput("t6_rstData", 32'(outIf.out_data), 32'd0);
      checkOutput("t6_rstLast", 32'(outIf.out_last), 32'd0);
      checkOutput("t6_rstBusy", 32'(busy), 32'd0);
      checkOutput("t6_rstDone", 32'(done), 32'd0);
      but = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();
      checkOutput("t6_noDone", 32'(doneCnt), 32'd0);
      applyStimulus("t6", 8'h02, 5, 1'b0, 1'b0, lat);
      checkFrame("t6", 1'b0, 2, 23, 2);

      // Randomized presses, stalls and table writes against the reference table.
      for (int r = 0; r < 30; r++) begin
         if ($urandom_range(0, 2) == 0) begin
            cfgWrite($urandom_range(0, NUM_ST - 1),
                     ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
                     $urandom_range(0, 255));
         end
         if ($urandom_range(0, 2) != 0) pat = 8'h01 << $urandom_range(0, 7);
         else                          pat = 8'($urandom_range(1, 255));
         modelPress(pat, expErr, eHdr, eFee, eId);
         applyStimulus($sformatf("rnd%0d", r), pat, $urandom_range(0, 15), 1'b1, 1'b1, lat);
         checkFrame($sformatf("rnd%0d", r), expErr, eHdr, eFee, eId);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
